// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: walks NDIG digit slots with guard gaps,
// double-buffers BCD data and swaps it in only at frame boundaries.
module seg_scan_ctrl #(
    parameter int NDIG     = 4,
    parameter int DIV_W    = 10,
    parameter int GUARD    = 2,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              load,
    input  logic [4*NDIG-1:0] bcd_in,
    output logic [3:0]        bcd_out,
    output logic              blank,
    output logic [NDIG-1:0]   dig_en,
    output logic              frame_done,
    output logic              upd_done
);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_GUARD = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DIV_W-1:0]  pre_q, pre_d;
    logic [3:0]        gcnt_q, gcnt_d;
    logic [4*NDIG-1:0] disp_q, disp_d;
    logic [4*NDIG-1:0] pend_q, pend_d;
    logic              pvld_q, pvld_d;

    logic [3:0]        bcd_out_q, bcd_out_d;
    logic              blank_q, blank_d;
    logic [NDIG-1:0]   dig_en_q, dig_en_d;
    logic              frame_done_q, upd_done_q, upd_d;

    logic              boundary;
    logic [3:0]        cur;
    logic              nz_above, lz;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pre_d    = pre_q;
        gcnt_d   = gcnt_q;
        boundary = 1'b0;
        if (!ena) begin
            state_d = S_IDLE;
            idx_d   = '0;
            pre_d   = '0;
            gcnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d  = S_SCAN;
                    idx_d    = '0;
                    pre_d    = '0;
                    boundary = 1'b1;
                end
                S_SCAN: begin
                    if (pre_q == '1) begin
                        state_d = S_GUARD;
                        pre_d   = '0;
                        gcnt_d  = '0;
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                S_GUARD: begin
                    if (gcnt_q == 4'(GUARD - 1)) begin
                        state_d = S_SCAN;
                        pre_d   = '0;
                        if (idx_q == IW'(NDIG - 1)) begin
                            idx_d    = '0;
                            boundary = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        gcnt_d = gcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    pre_d   = '0;
                    gcnt_d  = '0;
                end
            endcase
        end
    end

    // A load landing on the boundary cycle goes straight to the display register.
    always_comb begin
        disp_d = disp_q;
        pend_d = pend_q;
        pvld_d = pvld_q;
        upd_d  = 1'b0;
        if (boundary && load) begin
            disp_d = bcd_in;
            pend_d = bcd_in;
            pvld_d = 1'b0;
            upd_d  = 1'b1;
        end else begin
            if (boundary && pvld_q) begin
                disp_d = pend_q;
                pvld_d = 1'b0;
                upd_d  = 1'b1;
            end
            if (load) begin
                pend_d = bcd_in;
                pvld_d = 1'b1;
            end
        end
    end

    // Outputs are computed from next-state values so the registers track the FSM exactly.
    always_comb begin
        cur      = disp_d[{idx_d, 2'b00} +: 4];
        nz_above = 1'b0;
        for (int j = 0; j < NDIG; j++) begin
            if (j >= int'(idx_d) && disp_d[4*j +: 4] != 4'd0) nz_above = 1'b1;
        end
        lz = BLANK_LZ && (idx_d != '0) && !nz_above;
        if (state_d == S_SCAN) begin
            dig_en_d  = NDIG'(1) << idx_d;
            bcd_out_d = cur;
            blank_d   = (cur > 4'd9) || lz;
        end else begin
            dig_en_d  = '0;
            bcd_out_d = 4'd0;
            blank_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            pre_q        <= '0;
            gcnt_q       <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pvld_q       <= 1'b0;
            bcd_out_q    <= 4'd0;
            blank_q      <= 1'b1;
            dig_en_q     <= '0;
            frame_done_q <= 1'b0;
            upd_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pre_q        <= pre_d;
            gcnt_q       <= gcnt_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pvld_q       <= pvld_d;
            bcd_out_q    <= bcd_out_d;
            blank_q      <= blank_d;
            dig_en_q     <= dig_en_d;
            frame_done_q <= boundary;
            upd_done_q   <= upd_d;
        end
    end

    assign bcd_out    = bcd_out_q;
    assign blank      = blank_q;
    assign dig_en     = dig_en_q;
    assign frame_done = frame_done_q;
    assign upd_done   = upd_done_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: per-slot expected digit values queued per frame and
// compared as the scan reaches each slot; guard, pulse and reset behaviour checked inline.
module tb_seg_scan_ctrl;
    localparam int NDIG   = 4;
    localparam int DIV_W  = 2;
    localparam int GUARD  = 2;
    localparam int SLOT   = 1 << DIV_W;
    localparam int PERIOD = SLOT + GUARD;
    localparam int FRAME  = NDIG * PERIOD;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena;
    logic              load;
    logic [4*NDIG-1:0] bcd_in;
    logic [3:0]        bcd_out;
    logic              blank;
    logic [NDIG-1:0]   dig_en;
    logic              frame_done;
    logic              upd_done;

    int n_chk  = 0;
    int n_fail = 0;
    logic [8:0] exp_q[$];

    seg_scan_ctrl #(.NDIG(NDIG), .DIV_W(DIV_W), .GUARD(GUARD), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .load(load), .bcd_in(bcd_in),
        .bcd_out(bcd_out), .blank(blank), .dig_en(dig_en),
        .frame_done(frame_done), .upd_done(upd_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Expected {blank, bcd} for digit i of a packed value.
    function automatic logic [4:0] model_digit(input logic [15:0] v, input int i);
        logic [15:0] sh;
        logic [3:0]  nib;
        logic        bl;
        sh  = v >> (4 * i);
        nib = sh[3:0];
        bl  = (nib > 4'd9) || (i > 0 && sh == 16'd0);
        return {bl, nib};
    endfunction

    task automatic push_frame(input logic [15:0] v);
        logic [3:0] oh;
        for (int i = 0; i < NDIG; i++) begin
            oh = 4'b0001 << i;
            exp_q.push_back({oh, model_digit(v, i)});
        end
    endtask

    // Walks one frame from its first SCAN cycle, optionally pulsing load at two cycles.
    task automatic scoreboard_frame(input bit exp_upd, input int la1, input logic [15:0] lv1,
                                    input int la2, input logic [15:0] lv2);
        logic [8:0] expv;
        logic [8:0] got;
        logic [3:0] oh;
        int slot;
        int pos;
        for (int c = 0; c < FRAME; c++) begin
            slot = c / PERIOD;
            pos  = c % PERIOD;
            oh   = 4'b0001 << slot;
            got  = {dig_en, blank, bcd_out};
            if (pos == 0) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_empty: cycle %0d got %h, no expected entry", c, got);
                end else begin
                    expv = exp_q.pop_front();
                    if (got !== expv) begin
                        n_fail++;
                        $display("FAIL slot%0d: {dig_en,blank,bcd} got %h expected %h", slot, got, expv);
                    end
                end
            end else if (pos < SLOT) begin
                n_chk++;
                if (dig_en !== oh) begin
                    n_fail++;
                    $display("FAIL slot_hold c%0d: dig_en got %b expected %b", c, dig_en, oh);
                end
            end else begin
                n_chk++;
                if (got !== 9'b0000_1_0000) begin
                    n_fail++;
                    $display("FAIL guard c%0d: {dig_en,blank,bcd} got %h expected 010", c, got);
                end
            end
            n_chk++;
            if (frame_done !== (c == 0)) begin
                n_fail++;
                $display("FAIL frame_done c%0d: got %b expected %b", c, frame_done, (c == 0));
            end
            n_chk++;
            if (upd_done !== (c == 0 && exp_upd)) begin
                n_fail++;
                $display("FAIL upd_done c%0d: got %b expected %b", c, upd_done, (c == 0 && exp_upd));
            end
            load = (c == la1) || (c == la2);
            if (c == la2) bcd_in = lv2;
            else if (c == la1) bcd_in = lv1;
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    task automatic check_idle_outputs(input string name);
        n_chk++;
        if ({dig_en, blank, bcd_out, frame_done, upd_done} !== 11'b0000_1_0000_0_0) begin
            n_fail++;
            $display("FAIL %s: {dig_en,blank,bcd,fd,ud} got %b expected 00001000000", name,
                     {dig_en, blank, bcd_out, frame_done, upd_done});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b0; load = 1'b0; bcd_in = '0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("idle_after_reset");
    endtask

    task automatic test_scan();
        load = 1'b1; bcd_in = 16'h1239;
        @(negedge clk);
        load = 1'b0;
        check_idle_outputs("idle_load");
        ena = 1'b1;
        @(negedge clk);
        push_frame(16'h1239);
        scoreboard_frame(1'b1, -1, 16'h0, -1, 16'h0);
        push_frame(16'h1239);
        scoreboard_frame(1'b0, -1, 16'h0, -1, 16'h0);
    endtask

    task automatic test_leading_zero();
        push_frame(16'h1239);
        scoreboard_frame(1'b0, 5, 16'h0007, -1, 16'h0);
        push_frame(16'h0007);
        scoreboard_frame(1'b1, 10, 16'h0000, -1, 16'h0);
        push_frame(16'h0000);
        scoreboard_frame(1'b1, 3, 16'h0A05, -1, 16'h0);
        push_frame(16'h0A05);
        scoreboard_frame(1'b1, -1, 16'h0, -1, 16'h0);
    endtask

    task automatic test_last_wins();
        push_frame(16'h0A05);
        scoreboard_frame(1'b0, 2, 16'h4444, 14, 16'h5555);
        push_frame(16'h5555);
        scoreboard_frame(1'b1, -1, 16'h0, -1, 16'h0);
    endtask

    task automatic test_back_to_back();
        push_frame(16'h5555);
        scoreboard_frame(1'b0, FRAME - 1, 16'h0321, -1, 16'h0);
        push_frame(16'h0321);
        scoreboard_frame(1'b1, -1, 16'h0, -1, 16'h0);
        push_frame(16'h0321);
        scoreboard_frame(1'b0, -1, 16'h0, -1, 16'h0);
    endtask

    task automatic test_ena_drop();
        repeat (2 * PERIOD + SLOT) @(negedge clk);
        n_chk++;
        if (dig_en !== 4'b0000 || blank !== 1'b1) begin
            n_fail++;
            $display("FAIL guard_d2: dig_en got %b blank got %b expected 0000/1", dig_en, blank);
        end
        ena = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_idle_outputs("ena_drop_idle");
        end
        ena = 1'b1;
        @(negedge clk);
        push_frame(16'h0321);
        scoreboard_frame(1'b0, -1, 16'h0, -1, 16'h0);
    endtask

    task automatic test_reset_mid();
        repeat (2) @(negedge clk);
        n_chk++;
        if (dig_en !== 4'b0001 || bcd_out !== 4'd1) begin
            n_fail++;
            $display("FAIL pre_reset: dig_en got %b bcd got %h expected 0001/1", dig_en, bcd_out);
        end
        #1 rst_n = 1'b0;
        #1 check_idle_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_frame(16'h0000);
        scoreboard_frame(1'b0, -1, 16'h0, -1, 16'h0);
    endtask

    initial begin
        test_reset();
        test_scan();
        test_leading_zero();
        test_last_wins();
        test_back_to_back();
        test_ena_drop();
        test_reset_mid();
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d entries remain, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter: NDIG, 4, number of multiplexed digits (2..8).
REQ-002 Parameter: DIV_W, 10, refresh prescaler width; one digit slot lasts 2^DIV_W cycles.
REQ-003 Parameter: GUARD, 2, dead-time cycles with all digits off between slots (1..15).
REQ-004 Parameter: BLANK_LZ, 1, leading-zero blanking enable.
REQ-005 Port: clk  input  1  single clock, all state on rising edge.
REQ-006 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-007 Port: ena  input  1  scan enable; 0 forces IDLE.
REQ-008 Port: load  input  1  single-cycle request to capture bcd_in.
REQ-009 Port: bcd_in  input  4*NDIG  packed BCD digits, digit 0 in bits [3:0].
REQ-010 Port: bcd_out  output  4  BCD code to the shared BCD-to-7-segment decoder.
REQ-011 Port: blank  output  1  decoder blanking; 1 = all segments off.
REQ-012 Port: dig_en  output  NDIG  one-hot active-high digit select.
REQ-013 Port: frame_done  output  1  one-cycle pulse at each frame boundary.
REQ-014 Port: upd_done  output  1  one-cycle pulse when pending data enters the display register.

Function
REQ-015 The FSM SHALL have three states: IDLE, SCAN, GUARD; all outputs SHALL be registered.
REQ-016 IDLE->SCAN SHALL occur on the first edge with ena=1, with digit index 0 and prescaler 0.
REQ-017 In SCAN the prescaler SHALL increment every cycle; on reaching 2^DIV_W-1 the FSM SHALL enter GUARD and clear the prescaler.
REQ-018 GUARD SHALL last exactly GUARD cycles, then enter SCAN with index+1, wrapping NDIG-1 -> 0.
REQ-019 Frame length SHALL be NDIG*(2^DIV_W+GUARD) cycles.
REQ-020 In SCAN with index i: dig_en=1<<i, bcd_out=disp[i], blank=1 if disp[i]>9 or digit i is a leading zero, else 0.
REQ-021 Leading zero: BLANK_LZ=1, i>0, and disp[j]==0 for all j>=i; digit 0 SHALL never be LZ-blanked.
REQ-022 In IDLE and GUARD: dig_en=0, blank=1, bcd_out=0.
REQ-023 load=1 SHALL copy bcd_in into the pending register and set pend_valid; a second load before transfer overwrites (last wins).
REQ-024 The frame boundary SHALL be the GUARD->SCAN edge that wraps the index to 0; frame_done SHALL be 1 for that one cycle.
REQ-025 At a frame boundary with pend_valid=1: disp<=pending, pend_valid<=0, upd_done=1 for one cycle.
REQ-026 Simultaneous load and frame boundary SHALL bypass: disp<=bcd_in, pend_valid<=0, upd_done=1.
REQ-027 The first SCAN entry from IDLE SHALL count as a frame boundary (pending transfer, frame_done, upd_done).
REQ-028 ena=0 in any state SHALL enter IDLE next edge, clear index and prescaler, and retain disp and pending.
REQ-029 load SHALL be honoured in every state, including IDLE.

Reset
REQ-030 rst_n=0 SHALL immediately force: state IDLE, index 0, prescaler 0, disp=0, pending=0, pend_valid=0.
REQ-031 During reset: dig_en=0, blank=1, bcd_out=0, frame_done=0, upd_done=0.
REQ-032 Reset asserted mid-slot or mid-GUARD SHALL discard the slot; after release, operation resumes per REQ-016.

Verification (NDIG=4, DIV_W=2, GUARD=2, BLANK_LZ=1)
REQ-033 Reset, load bcd_in=0x1239, ena=1 -> first SCAN entry: upd_done=1, dig_en=0001, bcd_out=9; dig_en sequence 0001,0010,0100,1000 with bcd_out 9,3,2,1; 4 cycles per slot, 2 GUARD cycles (dig_en=0); frame_done every 24 cycles.
REQ-034 load 0x0007 -> digits 1..3 blank=1 and digit 0 shows 7; load 0x0000 -> only digit 0 unblanked, bcd_out=0; load 0x0A05 -> digit 2 blank=1, digit 3 LZ-blanked.
REQ-035 Mid-frame load 0x4444, then load 0x5555 -> displayed digits stay old until the boundary, then show 5; exactly one upd_done pulse.
REQ-036 load coincident with a boundary cycle -> new value shown in slot 0 of that same frame (bypass).
REQ-037 ena dropped during GUARD of digit 2 -> next cycle IDLE, dig_en=0, blank=1; re-enable -> restarts at digit 0 with frame_done=1.
REQ-038 rst_n pulsed low mid-slot -> outputs go to reset values without a clock edge; disp cleared, so digit 0 then shows 0.
